pram_load_bridge: RTL and testbench

PRAM_LOAD_BRIDGE -- requirements
Module: pram_load_bridge

---
 rtl/prz_pkg.sv | 20 ++
 rtl/bus_timeout_cnt.sv | 28 ++
 rtl/pram_load_bridge.sv | 100 ++++++++++
 tb/tb_pram_load_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prz_pkg.sv
// prz_pkg: shared load-bridge state encodings, default sizes and counter sizing helper.
package prz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    localparam int unsigned PRZ_PRAM_BYTES = 32'h0000_4000;
    localparam int unsigned PRZ_TIMEOUT    = 255;

    // The wait counter is never narrower than 8 bits, but must still hold larger limits.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return ($clog2(limit + 1) < 8) ? 8 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: counts bus wait cycles; expired flags the enabled cycle that would reach LIMIT.
module bus_timeout_cnt
    import prz_pkg::*;
#(
    parameter int unsigned LIMIT = PRZ_TIMEOUT,
    parameter int unsigned W     = cnt_width(LIMIT)
) (
    input  logic i_clk,
    input  logic i_a_reset_l,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_a_reset_l) begin
        if (!i_a_reset_l)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign expired = enable && (32'(cnt) + 32'd1 >= LIMIT);

endmodule

// File: rtl/pram_load_bridge.sv
// pram_load_bridge: copies a program image word by word from the external bus into program RAM,
// one outstanding read at a time, stepping with the external address sequencer.
module pram_load_bridge
    import prz_pkg::*;
#(
    parameter int unsigned PRAM_BYTES = PRZ_PRAM_BYTES,
    parameter int unsigned TIMEOUT    = PRZ_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_a_reset_l,
    input  logic        ld_from_ext,
    input  logic [15:0] addr_counter,
    output logic        i_bus_ready,
    output logic        o_bus_req,
    output logic [15:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err,
    output logic        o_pram_we,
    output logic [13:0] o_pram_addr,
    output logic [31:0] o_pram_wdata,
    output logic        o_load_done,
    output logic        o_load_err
);

    ld_state_e state;
    logic      ld_q;
    logic      in_req;
    logic      at_end;
    logic      ld_rise;
    logic      expired;

    assign in_req  = state == ST_REQ;
    assign at_end  = 32'(addr_counter) >= PRAM_BYTES;
    assign ld_rise = ld_from_ext && !ld_q;

    // Request is decoded from state so it sees the address the sequencer advanced on the write pulse.
    assign o_bus_req  = in_req && !at_end;
    assign o_bus_addr = o_bus_req ? addr_counter : '0;

    bus_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
        .i_clk       (i_clk),
        .i_a_reset_l (i_a_reset_l),
        .clear       (!in_req),
        .enable      (o_bus_req && !i_bus_ack),
        .expired     (expired)
    );

    always_ff @(posedge i_clk or negedge i_a_reset_l) begin
        if (!i_a_reset_l) begin
            state        <= ST_IDLE;
            ld_q         <= 1'b0;
            o_pram_we    <= 1'b0;
            i_bus_ready  <= 1'b0;
            o_pram_addr  <= '0;
            o_pram_wdata <= '0;
            o_load_done  <= 1'b0;
            o_load_err   <= 1'b0;
        end else begin
            ld_q        <= ld_from_ext;
            o_pram_we   <= 1'b0;
            i_bus_ready <= 1'b0;
            case (state)
                ST_IDLE:
                    if (ld_from_ext)
                        state <= ST_REQ;
                ST_REQ:
                    if (!ld_from_ext) begin
                        state <= ST_IDLE;
                    end else if (at_end) begin
                        state       <= ST_DONE;
                        o_load_done <= 1'b1;
                    end else if (i_bus_ack && i_bus_err) begin
                        state      <= ST_ERR;
                        o_load_err <= 1'b1;
                    end else if (i_bus_ack) begin
                        state        <= ST_WRITE;
                        o_pram_we    <= 1'b1;
                        i_bus_ready  <= 1'b1;
                        o_pram_addr  <= addr_counter[15:2];
                        o_pram_wdata <= i_bus_rdata;
                    end else if (expired) begin
                        state      <= ST_ERR;
                        o_load_err <= 1'b1;
                    end
                ST_WRITE:
                    state <= ld_from_ext ? ST_REQ : ST_IDLE;
                ST_DONE, ST_ERR:
                    if (ld_rise) begin
                        state       <= ST_REQ;
                        o_load_done <= 1'b0;
                        o_load_err  <= 1'b0;
                    end
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pram_load_bridge.sv
// tb_pram_load_bridge: sequencer and bus models with a write scoreboard around pram_load_bridge.
module tb_pram_load_bridge;

    logic        i_clk = 1'b0;
    logic        i_a_reset_l = 1'b1;
    logic        ld_from_ext = 1'b0;
    logic [15:0] addr_counter = '0;
    logic        i_bus_ready;
    logic        o_bus_req;
    logic [15:0] o_bus_addr;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    logic        i_bus_err = 1'b0;
    logic        o_pram_we;
    logic [13:0] o_pram_addr;
    logic [31:0] o_pram_wdata;
    logic        o_load_done;
    logic        o_load_err;

    int          cmp = 0;
    int          mism = 0;
    int          wr_cnt = 0;
    int          wcnt = 0;
    bit          ack_en = 1'b1;
    bit          err_en = 1'b0;
    logic [15:0] err_addr = '0;
    bit          seq_set = 1'b0;
    logic [15:0] seq_val = '0;
    logic [45:0] exp_q[$];
    logic [45:0] sb_e;

    pram_load_bridge dut (
        .i_clk        (i_clk),
        .i_a_reset_l  (i_a_reset_l),
        .ld_from_ext  (ld_from_ext),
        .addr_counter (addr_counter),
        .i_bus_ready  (i_bus_ready),
        .o_bus_req    (o_bus_req),
        .o_bus_addr   (o_bus_addr),
        .i_bus_ack    (i_bus_ack),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_err    (i_bus_err),
        .o_pram_we    (o_pram_we),
        .o_pram_addr  (o_pram_addr),
        .o_pram_wdata (o_pram_wdata),
        .o_load_done  (o_load_done),
        .o_load_err   (o_load_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] data_for(input logic [15:0] a);
        return (a == 16'h0100) ? 32'hDEADBEEF : {~a, a ^ 16'h5A5A};
    endfunction

    // Sequencer steps by 4 on each ready pulse; bus acks two cycles after a request starts.
    always @(posedge i_clk) begin
        if (seq_set)
            addr_counter <= seq_val;
        else if (i_bus_ready)
            addr_counter <= addr_counter + 16'd4;
        if (o_bus_req && !i_bus_ack) begin
            if (ack_en && wcnt == 1) begin
                i_bus_ack   <= 1'b1;
                i_bus_rdata <= data_for(o_bus_addr);
                i_bus_err   <= err_en && o_bus_addr == err_addr;
                if (!(err_en && o_bus_addr == err_addr))
                    exp_q.push_back({o_bus_addr[15:2], data_for(o_bus_addr)});
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            i_bus_ack <= 1'b0;
            i_bus_err <= 1'b0;
            if (!o_bus_req)
                wcnt <= 0;
        end
    end

    always @(negedge i_clk) begin
        if (i_a_reset_l && (o_pram_we || i_bus_ready)) begin
            cmp++;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                mism++;
                $display("FAIL sb_unexpected_write we=%b rdy=%b addr=%h data=%h expected no write",
                         o_pram_we, i_bus_ready, o_pram_addr, o_pram_wdata);
            end else begin
                sb_e = exp_q.pop_front();
                if ({o_pram_we, i_bus_ready, o_pram_addr, o_pram_wdata} !== {2'b11, sb_e}) begin
                    mism++;
                    $display("FAIL sb_write got we=%b rdy=%b addr=%h data=%h expected we=1 rdy=1 addr=%h data=%h",
                             o_pram_we, i_bus_ready, o_pram_addr, o_pram_wdata, sb_e[45:32], sb_e[31:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] a);
        ld_from_ext = 1'b0;
        ack_en      = 1'b1;
        err_en      = 1'b0;
        i_a_reset_l = 1'b0;
        seq_val     = a;
        seq_set     = 1'b1;
        tick(2);
        seq_set     = 1'b0;
        exp_q.delete();
        wr_cnt      = 0;
        i_a_reset_l = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        #1 i_a_reset_l = 1'b0;
        #1;
        cmp++;
        if ({o_bus_req, o_pram_we, i_bus_ready, o_load_done, o_load_err, o_bus_addr, o_pram_addr, o_pram_wdata} !== '0) begin
            mism++;
            $display("FAIL reset_outputs got req=%b we=%b rdy=%b done=%b err=%b baddr=%h paddr=%h wdata=%h expected all 0",
                     o_bus_req, o_pram_we, i_bus_ready, o_load_done, o_load_err, o_bus_addr, o_pram_addr, o_pram_wdata);
        end
        do_reset(16'h0000);
        ld_from_ext = 1'b1;
        tick(1);
        cmp++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 16'h0000}) begin
            mism++;
            $display("FAIL first_req got req=%b addr=%h expected req=1 addr=0000", o_bus_req, o_bus_addr);
        end
        i_a_reset_l = 1'b0;
        #1;
        cmp++;
        if ({o_bus_req, o_bus_addr} !== 17'd0) begin
            mism++;
            $display("FAIL async_reset_req got req=%b addr=%h expected req=0 addr=0000", o_bus_req, o_bus_addr);
        end
    endtask

    task automatic test_full_load;
        bit seen;
        do_reset(16'h0000);
        ld_from_ext = 1'b1;
        for (int i = 0; i < 30000 && !o_load_done; i++) @(negedge i_clk);
        cmp++;
        if ({o_load_done, o_load_err} !== 2'b10 || wr_cnt != 4096 || exp_q.size() != 0) begin
            mism++;
            $display("FAIL full_load got done=%b err=%b writes=%0d pending=%0d expected done=1 err=0 writes=4096 pending=0",
                     o_load_done, o_load_err, wr_cnt, exp_q.size());
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_bus_req) seen = 1'b1;
        end
        cmp++;
        if (seen !== 1'b0 || o_load_done !== 1'b1) begin
            mism++;
            $display("FAIL done_idle got req_seen=%b done=%b expected req_seen=0 done=1", seen, o_load_done);
        end
        @(posedge i_clk);
        #1 ld_from_ext = 1'b0;
        tick(1);
        cmp++;
        if (o_load_done !== 1'b1) begin
            mism++;
            $display("FAIL done_sticky got done=%b expected 1", o_load_done);
        end
        ld_from_ext = 1'b1;
        tick(1);
        cmp++;
        if (o_load_done !== 1'b0) begin
            mism++;
            $display("FAIL done_rearm got done=%b expected 0", o_load_done);
        end
    endtask

    task automatic test_bus_err;
        do_reset(16'h0000);
        err_en      = 1'b1;
        err_addr    = 16'h0010;
        ld_from_ext = 1'b1;
        for (int i = 0; i < 100 && !o_load_err; i++) @(negedge i_clk);
        cmp++;
        if ({o_load_err, o_bus_req} !== 2'b10 || wr_cnt != 4) begin
            mism++;
            $display("FAIL bus_err got err=%b req=%b writes=%0d expected err=1 req=0 writes=4",
                     o_load_err, o_bus_req, wr_cnt);
        end
        repeat (10) @(negedge i_clk);
        cmp++;
        if (wr_cnt != 4 || o_load_err !== 1'b1) begin
            mism++;
            $display("FAIL bus_err_hold got writes=%0d err=%b expected writes=4 err=1", wr_cnt, o_load_err);
        end
        @(posedge i_clk);
        #1 ld_from_ext = 1'b0;
        err_en = 1'b0;
        tick(1);
        ld_from_ext = 1'b1;
        tick(1);
        cmp++;
        if ({o_load_err, o_bus_req, o_bus_addr} !== {2'b01, 16'h0010}) begin
            mism++;
            $display("FAIL err_rearm got err=%b req=%b addr=%h expected err=0 req=1 addr=0010",
                     o_load_err, o_bus_req, o_bus_addr);
        end
    endtask

    task automatic test_timeout;
        int c;
        do_reset(16'h0000);
        ack_en      = 1'b0;
        ld_from_ext = 1'b1;
        for (int i = 0; i < 10 && !o_bus_req; i++) @(negedge i_clk);
        c = 1;
        for (int i = 0; i < 400 && !o_load_err; i++) begin
            @(negedge i_clk);
            c++;
        end
        cmp++;
        if (c != 256 || {o_load_err, o_bus_req} !== 2'b10 || wr_cnt != 0) begin
            mism++;
            $display("FAIL timeout got cycle=%0d err=%b req=%b writes=%0d expected cycle=256 err=1 req=0 writes=0",
                     c, o_load_err, o_bus_req, wr_cnt);
        end
    endtask

    task automatic test_abort;
        do_reset(16'h0020);
        ld_from_ext = 1'b1;
        for (int i = 0; i < 10 && !o_bus_req; i++) @(negedge i_clk);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 ld_from_ext = 1'b0;
        @(negedge i_clk);
        cmp++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 16'h0020}) begin
            mism++;
            $display("FAIL abort_hold got req=%b addr=%h expected req=1 addr=0020", o_bus_req, o_bus_addr);
        end
        @(negedge i_clk);
        cmp++;
        if ({o_bus_req, i_bus_ready, o_pram_we} !== 3'b000) begin
            mism++;
            $display("FAIL abort_drop got req=%b rdy=%b we=%b expected 0 0 0", o_bus_req, i_bus_ready, o_pram_we);
        end
        repeat (5) @(negedge i_clk);
        cmp++;
        if (wr_cnt != 0 || o_bus_req !== 1'b0) begin
            mism++;
            $display("FAIL abort_idle got writes=%0d req=%b expected writes=0 req=0", wr_cnt, o_bus_req);
        end
    endtask

    task automatic test_reset_in_write;
        do_reset(16'h0000);
        ld_from_ext = 1'b1;
        for (int i = 0; i < 100 && !(o_pram_we && o_pram_addr == 14'd2); i++) @(negedge i_clk);
        #1 i_a_reset_l = 1'b0;
        #1;
        cmp++;
        if ({o_pram_we, o_bus_req, i_bus_ready} !== 3'b000) begin
            mism++;
            $display("FAIL reset_in_write got we=%b req=%b rdy=%b expected 0 0 0", o_pram_we, o_bus_req, i_bus_ready);
        end
        do_reset(16'h0000);
        ld_from_ext = 1'b1;
        for (int i = 0; i < 10 && !o_bus_req; i++) @(negedge i_clk);
        cmp++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 16'h0000}) begin
            mism++;
            $display("FAIL restart_addr got req=%b addr=%h expected req=1 addr=0000", o_bus_req, o_bus_addr);
        end
        for (int i = 0; i < 10 && !o_pram_we; i++) @(negedge i_clk);
        cmp++;
        if ({o_pram_we, o_pram_addr, o_pram_wdata} !== {1'b1, 14'd0, data_for(16'h0000)}) begin
            mism++;
            $display("FAIL restart_write got we=%b addr=%h data=%h expected we=1 addr=0000 data=%h",
                     o_pram_we, o_pram_addr, o_pram_wdata, data_for(16'h0000));
        end
    endtask

    task automatic test_back_to_back;
        do_reset(16'h0100);
        ld_from_ext = 1'b1;
        for (int i = 0; i < 20 && !i_bus_ack; i++) @(negedge i_clk);
        @(negedge i_clk);
        cmp++;
        if ({o_pram_we, i_bus_ready, o_pram_addr, o_pram_wdata} !== {2'b11, 14'h040, 32'hDEADBEEF}) begin
            mism++;
            $display("FAIL write_0100 got we=%b rdy=%b addr=%h data=%h expected we=1 rdy=1 addr=0040 data=deadbeef",
                     o_pram_we, i_bus_ready, o_pram_addr, o_pram_wdata);
        end
        @(negedge i_clk);
        cmp++;
        if ({o_bus_req, o_bus_addr, o_pram_we} !== {1'b1, 16'h0104, 1'b0}) begin
            mism++;
            $display("FAIL next_req got req=%b addr=%h we=%b expected req=1 addr=0104 we=0",
                     o_bus_req, o_bus_addr, o_pram_we);
        end
        for (int i = 0; i < 100 && wr_cnt < 8; i++) @(negedge i_clk);
        cmp++;
        if (wr_cnt != 8 || addr_counter != 16'h0120) begin
            mism++;
            $display("FAIL back_to_back got writes=%0d seq_addr=%h expected writes=8 seq_addr=0120", wr_cnt, addr_counter);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_bus_err();
        test_timeout();
        test_abort();
        test_reset_in_write();
        test_back_to_back();
        do_reset(16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
